exec_mem_unit: RTL and testbench

Execute-and-memory core of the 8-bit pipelined processor. It combines three parts:
- an 8-bit ALU;
- an 8-bit barrel shifter;
- a 256x8 data memory;
plus the architectural carry (C) and zero (Z) flag registers. The EX stage drives the ALU, shifter and flag controls. The MEM stage drives the memory port.

---
 rtl/exec_pkg.sv | 26 ++
 rtl/alu8.sv | 39 +++
 rtl/barrel_shift8.sv | 51 +++++
 rtl/data_mem256.sv | 31 +++
 rtl/exec_mem_unit.sv | 84 ++++++++
 tb/tb_exec_mem_unit.sv | 254 +++++++++++++++++++++++++
 6 files changed

// File: rtl/exec_pkg.sv
// Shared constants and encodings for the execute/memory core.
package exec_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    // ALU operation encodings as driven on alu_op
    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_AND    = 3'b010,
        ALU_OR     = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_PASS_B = 3'b101,
        ALU_NOT_A  = 3'b110,
        ALU_RSV    = 3'b111
    } alu_op_e;

    // Shifter direction and mode encodings
    localparam logic SHIFT_LEFT    = 1'b0;
    localparam logic SHIFT_RIGHT   = 1'b1;
    localparam logic SHIFT_ROTATE  = 1'b0;
    localparam logic SHIFT_LOGICAL = 1'b1;

endpackage

// File: rtl/alu8.sv
// 8-bit combinational ALU with carry/borrow out and zero detect.
module alu8
    import exec_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_cin,
    output logic [DATA_W-1:0] o_out,
    output logic              o_co,
    output logic              o_z
);

    logic [DATA_W:0] w_wide;
    logic [DATA_W:0] w_cin_ext;

    assign w_cin_ext = {{DATA_W{1'b0}}, i_cin};

    // Result is computed one bit wider so bit DATA_W carries the carry
    // (ADD) or the borrow (SUB, wraps to 1 whenever A < B + cin).
    always_comb begin
        w_wide = '0;
        case (alu_op_e'(i_op))
            ALU_ADD:    w_wide = {1'b0, i_a} + {1'b0, i_b} + w_cin_ext;
            ALU_SUB:    w_wide = {1'b0, i_a} - {1'b0, i_b} - w_cin_ext;
            ALU_AND:    w_wide = {1'b0, i_a & i_b};
            ALU_OR:     w_wide = {1'b0, i_a | i_b};
            ALU_XOR:    w_wide = {1'b0, i_a ^ i_b};
            ALU_PASS_B: w_wide = {1'b0, i_b};
            ALU_NOT_A:  w_wide = {1'b0, ~i_a};
            default:    w_wide = '0;
        endcase
    end

    assign o_out = w_wide[DATA_W-1:0];
    assign o_co  = w_wide[DATA_W];
    assign o_z   = (o_out == '0);

endmodule

// File: rtl/barrel_shift8.sv
// 8-bit combinational barrel shifter: logical shift or rotate, either way.
module barrel_shift8
    import exec_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [2:0]        i_count,
    input  logic              i_dir,
    input  logic              i_logical,
    output logic [DATA_W-1:0] o_out,
    output logic              o_c,
    output logic              o_z
);

    // Double-width views: the bit shifted just past the word edge lands in
    // the adjacent half, which gives the logical-shift carry for free.
    logic [2*DATA_W-1:0] w_lsl;
    logic [2*DATA_W-1:0] w_lsr;
    logic [2*DATA_W-1:0] w_rol;
    logic [2*DATA_W-1:0] w_ror;

    assign w_lsl = {{DATA_W{1'b0}}, i_data} << i_count;
    assign w_lsr = {i_data, {DATA_W{1'b0}}} >> i_count;
    assign w_rol = {i_data, i_data} << i_count;
    assign w_ror = {i_data, i_data} >> i_count;

    // Select result and carry; a zero count never produces a carry.
    always_comb begin
        o_out = i_data;
        o_c   = 1'b0;
        if (i_logical == SHIFT_LOGICAL) begin
            if (i_dir == SHIFT_RIGHT) begin
                o_out = w_lsr[2*DATA_W-1:DATA_W];
                o_c   = w_lsr[DATA_W-1];
            end else begin
                o_out = w_lsl[DATA_W-1:0];
                o_c   = w_lsl[DATA_W];
            end
        end else begin
            if (i_dir == SHIFT_RIGHT) begin
                o_out = w_ror[DATA_W-1:0];
                o_c   = (i_count != 3'd0) && o_out[DATA_W-1];
            end else begin
                o_out = w_rol[2*DATA_W-1:DATA_W];
                o_c   = (i_count != 3'd0) && o_out[0];
            end
        end
    end

    assign o_z = (o_out == '0);

endmodule

// File: rtl/data_mem256.sv
// 256x8 data memory: synchronous write, asynchronous read, cleared on reset.
module data_mem256
    import exec_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    // Flop-based storage: the whole array must clear while reset is held,
    // which a block RAM cannot do.
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // Clear every word on reset, otherwise write the addressed word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read-before-write on a shared address falls out of the async read.
    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory core: ALU, barrel shifter, data memory and C/Z flags.
module exec_mem_unit #(
    parameter int DATA_W = exec_pkg::DATA_W,
    parameter int ADDR_W = exec_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic              alu_use_carry,
    output logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] shift_data,
    input  logic [2:0]        shift_count,
    input  logic              shift_dir,
    input  logic              shift_ro_bar,
    output logic [DATA_W-1:0] shift_out,
    input  logic              select_c,
    input  logic              select_z,
    input  logic              write_c,
    input  logic              write_z,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              C,
    output logic              Z
);

    logic r_c;
    logic r_z;
    logic w_alu_co;
    logic w_alu_z;
    logic w_sh_c;
    logic w_sh_z;
    logic w_cin;

    // Carry-in comes from the registered flag only: no same-cycle bypass.
    assign w_cin = alu_use_carry & r_c;

    alu8 u_alu (
        .i_op  (alu_op),
        .i_a   (alu_a),
        .i_b   (alu_b),
        .i_cin (w_cin),
        .o_out (alu_out),
        .o_co  (w_alu_co),
        .o_z   (w_alu_z)
    );

    barrel_shift8 u_shift (
        .i_data    (shift_data),
        .i_count   (shift_count),
        .i_dir     (shift_dir),
        .i_logical (shift_ro_bar),
        .o_out     (shift_out),
        .o_c       (w_sh_c),
        .o_z       (w_sh_z)
    );

    data_mem256 u_mem (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_we    (mem_write),
        .i_addr  (mem_addr),
        .i_wdata (mem_wdata),
        .o_rdata (mem_rdata)
    );

    // Independent C and Z updates; each flag holds unless its write is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c <= 1'b0;
            r_z <= 1'b0;
        end else begin
            if (write_c) r_c <= select_c ? w_sh_c : w_alu_co;
            if (write_z) r_z <= select_z ? w_sh_z : w_alu_z;
        end
    end

    assign C = r_c;
    assign Z = r_z;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: directed scenarios plus a random run
// against an arithmetic reference model.
module tb_exec_mem_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_use_carry;
    logic [7:0] alu_out;
    logic [7:0] shift_data;
    logic [2:0] shift_count;
    logic       shift_dir, shift_ro_bar;
    logic [7:0] shift_out;
    logic       select_c, select_z, write_c, write_z;
    logic       mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       C, Z;

    int checks = 0;
    int failures = 0;

    // Reference state
    bit       m_c, m_z;
    bit [7:0] m_mem [256];

    always #5 clk = ~clk;

    exec_mem_unit dut (
        .clk(clk), .reset(reset),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_use_carry(alu_use_carry), .alu_out(alu_out),
        .shift_data(shift_data), .shift_count(shift_count),
        .shift_dir(shift_dir), .shift_ro_bar(shift_ro_bar), .shift_out(shift_out),
        .select_c(select_c), .select_z(select_z),
        .write_c(write_c), .write_z(write_z),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .C(C), .Z(Z)
    );

    // ALU reference using integer arithmetic
    function automatic void ref_alu(input int op, input int a, input int b, input int cin,
                                    output int res, output bit co);
        int s;
        co = 1'b0;
        case (op)
            0: begin s = a + b + cin; res = s % 256; co = (s > 255); end
            1: begin s = a - b - cin; res = (s + 512) % 256; co = (a < b + cin); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = b;
            6: res = 255 - a;
            default: res = 0;
        endcase
    endfunction

    // Shifter reference using integer arithmetic
    function automatic void ref_shift(input int d, input int n, input bit dir, input bit logical,
                                      output int res, output bit c);
        c = 1'b0;
        if (n == 0) begin
            res = d;
        end else if (logical && !dir) begin
            res = (d * (1 << n)) % 256;
            c = ((d / (1 << (8 - n))) % 2) == 1;
        end else if (logical && dir) begin
            res = d / (1 << n);
            c = ((d / (1 << (n - 1))) % 2) == 1;
        end else if (!dir) begin
            res = ((d * (1 << n)) % 256) + d / (1 << (8 - n));
            c = (res % 2) == 1;
        end else begin
            res = d / (1 << n) + (d * (1 << (8 - n))) % 256;
            c = res >= 128;
        end
    endfunction

    task automatic set_idle();
        alu_op = 3'd0; alu_a = 8'h00; alu_b = 8'h00; alu_use_carry = 1'b0;
        shift_data = 8'h00; shift_count = 3'd0; shift_dir = 1'b0; shift_ro_bar = 1'b1;
        select_c = 1'b0; select_z = 1'b0; write_c = 1'b0; write_z = 1'b0;
        mem_write = 1'b0; mem_addr = 8'h00; mem_wdata = 8'h00;
    endtask

    // Advance one clock, updating the reference model from the applied inputs
    task automatic tick();
        int ar, sr;
        bit aco, sc;
        ref_alu(int'(alu_op), int'(alu_a), int'(alu_b), (alu_use_carry && m_c) ? 1 : 0, ar, aco);
        ref_shift(int'(shift_data), int'(shift_count), shift_dir, shift_ro_bar, sr, sc);
        $display("txn t=%0t op=%0d a=%h b=%h sd=%h n=%0d dir=%0d lg=%0d wc=%0d wz=%0d we=%0d addr=%h wd=%h",
                 $time, alu_op, alu_a, alu_b, shift_data, shift_count, shift_dir, shift_ro_bar,
                 write_c, write_z, mem_write, mem_addr, mem_wdata);
        @(posedge clk);
        if (write_c) m_c = select_c ? sc : aco;
        if (write_z) m_z = select_z ? (sr == 0) : (ar == 0);
        if (mem_write) m_mem[mem_addr] = mem_wdata;
        #1;
    endtask

    task automatic test_reset();
        // Put nonzero state in memory and flags, then reset with writes still asserted
        set_idle();
        alu_op = 3'd0; alu_a = 8'hFF; alu_b = 8'h01; write_c = 1'b1; write_z = 1'b1;
        mem_write = 1'b1; mem_addr = 8'h05; mem_wdata = 8'h3C;
        tick();
        mem_write = 1'b0;
        @(negedge clk);
        checks++; if (mem_rdata !== 8'h3C) begin failures++; $display("FAIL pre_reset_mem got=%h exp=%h", mem_rdata, 8'h3C); end
        checks++; if (C !== 1'b1) begin failures++; $display("FAIL pre_reset_c got=%b exp=1", C); end
        @(posedge clk); #1;
        mem_write = 1'b1; mem_wdata = 8'h99;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle(); mem_addr = 8'h05;
        m_c = 1'b0; m_z = 1'b0;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        @(negedge clk);
        checks++; if (C !== 1'b0) begin failures++; $display("FAIL reset_c got=%b exp=0", C); end
        checks++; if (Z !== 1'b0) begin failures++; $display("FAIL reset_z got=%b exp=0", Z); end
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL reset_mem5 got=%h exp=00", mem_rdata); end
        tick();
    endtask

    task automatic test_add_adc();
        set_idle();
        alu_op = 3'd0; alu_a = 8'hFF; alu_b = 8'h01; write_c = 1'b1; write_z = 1'b1;
        @(negedge clk);
        checks++; if (alu_out !== 8'h00) begin failures++; $display("FAIL add_ff_01 got=%h exp=00", alu_out); end
        tick();
        checks++; if (C !== 1'b1) begin failures++; $display("FAIL add_c got=%b exp=1", C); end
        checks++; if (Z !== 1'b1) begin failures++; $display("FAIL add_z got=%b exp=1", Z); end
        alu_a = 8'h10; alu_b = 8'h20; alu_use_carry = 1'b1;
        @(negedge clk);
        checks++; if (alu_out !== 8'h31) begin failures++; $display("FAIL adc got=%h exp=31", alu_out); end
        tick();
        checks++; if (C !== 1'b0 || Z !== 1'b0) begin failures++; $display("FAIL adc_flags got=%b%b exp=00", C, Z); end
    endtask

    task automatic test_sub();
        set_idle();
        alu_op = 3'd1; alu_a = 8'h05; alu_b = 8'h07; write_c = 1'b1;
        @(negedge clk);
        checks++; if (alu_out !== 8'hFE) begin failures++; $display("FAIL sub_borrow got=%h exp=fe", alu_out); end
        tick();
        checks++; if (C !== 1'b1) begin failures++; $display("FAIL sub_borrow_c got=%b exp=1", C); end
        alu_a = 8'h07; alu_b = 8'h05;
        @(negedge clk);
        checks++; if (alu_out !== 8'h02) begin failures++; $display("FAIL sub_plain got=%h exp=02", alu_out); end
        tick();
        checks++; if (C !== 1'b0) begin failures++; $display("FAIL sub_plain_c got=%b exp=0", C); end
    endtask

    task automatic test_shifter();
        set_idle();
        shift_data = 8'h81; shift_count = 3'd1; shift_dir = 1'b0; shift_ro_bar = 1'b1;
        select_c = 1'b1; write_c = 1'b1;
        @(negedge clk);
        checks++; if (shift_out !== 8'h02) begin failures++; $display("FAIL lsl_81_1 got=%h exp=02", shift_out); end
        tick();
        checks++; if (C !== 1'b1) begin failures++; $display("FAIL lsl_c got=%b exp=1", C); end
        shift_data = 8'h01; shift_count = 3'd3; shift_dir = 1'b1; shift_ro_bar = 1'b0;
        @(negedge clk);
        checks++; if (shift_out !== 8'h20) begin failures++; $display("FAIL ror_01_3 got=%h exp=20", shift_out); end
        tick();
        checks++; if (C !== 1'b0) begin failures++; $display("FAIL ror_c got=%b exp=0", C); end
        shift_data = 8'h0F; shift_count = 3'd4; shift_dir = 1'b1; shift_ro_bar = 1'b1;
        write_c = 1'b0; select_z = 1'b1; write_z = 1'b1;
        @(negedge clk);
        checks++; if (shift_out !== 8'h00) begin failures++; $display("FAIL lsr_0f_4 got=%h exp=00", shift_out); end
        tick();
        checks++; if (Z !== 1'b1) begin failures++; $display("FAIL lsr_z got=%b exp=1", Z); end
    endtask

    task automatic test_flag_hold();
        set_idle();
        alu_op = 3'd0; alu_a = 8'hFF; alu_b = 8'h02; write_c = 1'b1;
        tick();
        checks++; if (C !== 1'b1) begin failures++; $display("FAIL hold_setup_c got=%b exp=1", C); end
        set_idle();
        alu_op = 3'd5; alu_b = 8'h42; write_z = 1'b1;
        tick();
        checks++; if (C !== 1'b1) begin failures++; $display("FAIL hold_c got=%b exp=1", C); end
        checks++; if (Z !== 1'b0) begin failures++; $display("FAIL hold_z got=%b exp=0", Z); end
    endtask

    task automatic test_memory();
        set_idle();
        mem_write = 1'b1; mem_addr = 8'h10; mem_wdata = 8'hA5; tick();
        mem_addr = 8'hFF; mem_wdata = 8'h5A; tick();
        mem_write = 1'b0; mem_wdata = 8'hEE;
        mem_addr = 8'h10; tick();
        checks++; if (mem_rdata !== 8'hA5) begin failures++; $display("FAIL mem_10 got=%h exp=a5", mem_rdata); end
        mem_addr = 8'hFF; #1;
        checks++; if (mem_rdata !== 8'h5A) begin failures++; $display("FAIL mem_ff got=%h exp=5a", mem_rdata); end
        mem_addr = 8'h11; #1;
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL mem_11 got=%h exp=00", mem_rdata); end
        // Read-before-write on the same address
        mem_addr = 8'h20; mem_wdata = 8'h77; mem_write = 1'b1;
        @(negedge clk);
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL rbw_old got=%h exp=00", mem_rdata); end
        tick();
        mem_write = 1'b0;
        checks++; if (mem_rdata !== 8'h77) begin failures++; $display("FAIL rbw_new got=%h exp=77", mem_rdata); end
    endtask

    task automatic test_random();
        int ar, sr;
        bit aco, sc;
        for (int it = 0; it < 300; it++) begin
            alu_op = 3'($urandom); alu_a = 8'($urandom); alu_b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) alu_b = alu_a;
            alu_use_carry = 1'($urandom);
            shift_data = 8'($urandom); shift_count = 3'($urandom);
            shift_dir = 1'($urandom); shift_ro_bar = 1'($urandom);
            select_c = 1'($urandom); select_z = 1'($urandom);
            write_c = 1'($urandom); write_z = 1'($urandom);
            mem_write = 1'($urandom);
            mem_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            mem_wdata = 8'($urandom);
            ref_alu(int'(alu_op), int'(alu_a), int'(alu_b), (alu_use_carry && m_c) ? 1 : 0, ar, aco);
            ref_shift(int'(shift_data), int'(shift_count), shift_dir, shift_ro_bar, sr, sc);
            @(negedge clk);
            checks++; if (alu_out !== 8'(ar)) begin failures++; $display("FAIL rnd_alu it=%0d op=%0d got=%h exp=%h", it, alu_op, alu_out, 8'(ar)); end
            checks++; if (shift_out !== 8'(sr)) begin failures++; $display("FAIL rnd_shift it=%0d got=%h exp=%h", it, shift_out, 8'(sr)); end
            checks++; if (mem_rdata !== m_mem[mem_addr]) begin failures++; $display("FAIL rnd_mem it=%0d addr=%h got=%h exp=%h", it, mem_addr, mem_rdata, m_mem[mem_addr]); end
            tick();
            checks++; if (C !== m_c) begin failures++; $display("FAIL rnd_c it=%0d got=%b exp=%b", it, C, m_c); end
            checks++; if (Z !== m_z) begin failures++; $display("FAIL rnd_z it=%0d got=%b exp=%b", it, Z, m_z); end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        m_c = 1'b0; m_z = 1'b0;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_add_adc();
        test_sub();
        test_shifter();
        test_flag_hold();
        test_memory();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
